// File: rtl/debug_frame_tx.sv
// Debug snapshot framer: latches a window of a wide debug bus and streams it
// byte-by-byte to a UART as [header] payload [xor checksum].
module debug_frame_tx #(
  parameter int unsigned BUS_WIDTH    = 1696,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter bit          USE_HEADER   = 1'b1,
  parameter bit          USE_CHECKSUM = 1'b1,
  localparam int unsigned NBYTES      = BUS_WIDTH / 8,
  localparam int unsigned IW          = $clog2(NBYTES + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic [IW-1:0]        win_start,
  input  logic [IW-1:0]        win_len,
  input  logic                 tx_busy,
  output logic                 wr_uart,
  output logic [7:0]           w_data,
  output logic                 busy,
  output logic                 dataSent,
  output logic [7:0]           frame_count
);

  localparam int unsigned SW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BYTE,
    S_WAIT_ACK,
    S_WAIT_FREE,
    S_CHK,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] snap_q, snap_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        end_q, end_d;
  logic [7:0]           csum_q, csum_d;
  logic                 chk_sent_q, chk_sent_d;
  logic                 wr_uart_q, wr_uart_d;
  logic [7:0]           w_data_q, w_data_d;
  logic                 busy_q, busy_d;
  logic                 data_sent_q, data_sent_d;
  logic [7:0]           frame_count_q, frame_count_d;

  logic [IW-1:0] win_len_eff_c;
  logic [SW-1:0] win_sum_c;
  logic [IW-1:0] win_end_c;
  logic [7:0]    cur_byte_c;

  // Window end, clamped to the bus; the sum is one bit wider so it cannot wrap
  always_comb begin
    win_len_eff_c = (win_len == '0) ? IW'(NBYTES) : win_len;
    win_sum_c     = SW'(win_start) + SW'(win_len_eff_c);
    win_end_c     = (win_sum_c > SW'(NBYTES)) ? IW'(NBYTES) : win_sum_c[IW-1:0];
  end

  // Byte idx of the snapshot, byte 0 being the most significant
  assign cur_byte_c = 8'((snap_q << {idx_q, 3'b000}) >> (BUS_WIDTH - 8));

  function automatic state_t after_payload(input logic more, input logic chk_sent);
    if (more) return S_BYTE;
    else if (USE_CHECKSUM && !chk_sent) return S_CHK;
    else return S_FIN;
  endfunction

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    idx_d         = idx_q;
    end_d         = end_q;
    csum_d        = csum_q;
    chk_sent_d    = chk_sent_q;
    wr_uart_d     = 1'b0;
    w_data_d      = w_data_q;
    busy_d        = busy_q;
    data_sent_d   = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (send) begin
          snap_d     = data_in;
          idx_d      = win_start;
          end_d      = win_end_c;
          csum_d     = 8'h00;
          chk_sent_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = USE_HEADER ? S_HDR : after_payload(win_start < win_end_c, 1'b0);
        end
      end
      S_HDR: begin
        if (!tx_busy) begin
          wr_uart_d = 1'b1;
          w_data_d  = HEADER;
          state_d   = S_WAIT_ACK;
        end
      end
      S_BYTE: begin
        if (!tx_busy) begin
          wr_uart_d = 1'b1;
          w_data_d  = cur_byte_c;
          csum_d    = csum_q ^ cur_byte_c;
          idx_d     = idx_q + IW'(1);
          state_d   = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) state_d = S_WAIT_FREE;
      end
      S_WAIT_FREE: begin
        if (!tx_busy) state_d = after_payload(idx_q < end_q, chk_sent_q);
      end
      S_CHK: begin
        if (!tx_busy) begin
          wr_uart_d  = 1'b1;
          w_data_d   = csum_q;
          chk_sent_d = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end
      S_FIN: begin
        data_sent_d   = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      snap_q        <= '0;
      idx_q         <= '0;
      end_q         <= '0;
      csum_q        <= 8'h00;
      chk_sent_q    <= 1'b0;
      wr_uart_q     <= 1'b0;
      w_data_q      <= 8'h00;
      busy_q        <= 1'b0;
      data_sent_q   <= 1'b0;
      frame_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      idx_q         <= idx_d;
      end_q         <= end_d;
      csum_q        <= csum_d;
      chk_sent_q    <= chk_sent_d;
      wr_uart_q     <= wr_uart_d;
      w_data_q      <= w_data_d;
      busy_q        <= busy_d;
      data_sent_q   <= data_sent_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign wr_uart     = wr_uart_q;
  assign w_data      = w_data_q;
  assign busy        = busy_q;
  assign dataSent    = data_sent_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx on a 32-bit bus with a simple UART busy model.
module tb_debug_frame_tx;

  localparam int unsigned BW = 32;
  localparam int unsigned IW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          send;
  logic [BW-1:0] data_in;
  logic [IW-1:0] win_start;
  logic [IW-1:0] win_len;
  logic          tx_busy;
  logic          wr_uart;
  logic [7:0]    w_data;
  logic          busy;
  logic          dataSent;
  logic [7:0]    frame_count;

  debug_frame_tx #(
    .BUS_WIDTH   (BW),
    .HEADER      (8'hA5),
    .USE_HEADER  (1'b1),
    .USE_CHECKSUM(1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .send       (send),
    .data_in    (data_in),
    .win_start  (win_start),
    .win_len    (win_len),
    .tx_busy    (tx_busy),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .busy       (busy),
    .dataSent   (dataSent),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  // UART model: busy one cycle after a write strobe, held for 4 cycles
  logic [2:0] ux_cnt;
  assign tx_busy = (ux_cnt != 3'd0);
  always @(posedge clock) begin
    if (reset) ux_cnt <= 3'd0;
    else if (wr_uart) ux_cnt <= 3'd4;
    else if (ux_cnt != 3'd0) ux_cnt <= ux_cnt - 3'd1;
  end

  // Byte capture and pulse counting
  logic [7:0] cap[$];
  int ds_cnt = 0;
  int viol   = 0;
  always @(posedge clock) begin
    if (wr_uart === 1'b1) begin
      cap.push_back(w_data);
      if (tx_busy === 1'b1) viol <= viol + 1;
    end
    if (dataSent === 1'b1) ds_cnt <= ds_cnt + 1;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp, input int n);
    check($sformatf("%s_len", tag), 32'(cap.size()), 32'(n));
    for (int i = 0; i < n && i < cap.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(exp[63-8*i -: 8]));
  endtask

  function automatic bit frame_ok(input logic [63:0] exp, input int n);
    if (cap.size() != n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (cap[i] !== exp[63-8*i -: 8]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [BW-1:0] d, input logic [IW-1:0] ws, input logic [IW-1:0] wl);
    data_in = d; win_start = ws; win_len = wl; send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ds_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  task automatic run_frame(input string tag, input logic [BW-1:0] d, input logic [IW-1:0] ws,
                           input logic [IW-1:0] wl, input logic [63:0] exp, input int n,
                           input logic [7:0] fc_exp);
    int base;
    bit ok;
    cap.delete();
    base = ds_cnt;
    start_frame(d, ws, wl);
    wait_done(base + 1, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check_frame(tag, exp, n);
    check({tag, "_fc"}, 32'(frame_count), 32'(fc_exp));
  endtask

  initial begin
    int  base;
    int  bad;
    bit  ok;
    reset = 1'b1; send = 1'b0; data_in = '0; win_start = '0; win_len = '0;
    repeat (3) @(negedge clock);
    check("rst_wr", 32'(wr_uart), 32'd0);
    check("rst_wdata", 32'(w_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ds", 32'(dataSent), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Full bus frame with latency checks
    cap.delete();
    base = ds_cnt;
    start_frame(32'h11223344, 3'd0, 3'd0);
    check("t1_busy_acc", 32'(busy), 32'd1);
    check("t1_wr_acc", 32'(wr_uart), 32'd0);
    @(negedge clock);
    check("t1_wr_first", 32'(wr_uart), 32'd1);
    check("t1_hdr", 32'(w_data), 32'hA5);
    wait_done(base + 1, ok);
    check("t1_done", 32'(ok), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check_frame("t1", 64'hA511223344440000, 6);
    check("t1_fc", 32'(frame_count), 32'd1);
    repeat (10) @(negedge clock);
    check("t1_ds_once", 32'(ds_cnt - base), 32'd1);

    run_frame("t2", 32'h11223344, 3'd1, 3'd2, 64'hA522331100000000, 4, 8'd2);
    run_frame("t3_clamp", 32'h11223344, 3'd3, 3'd4, 64'hA544440000000000, 3, 8'd3);
    run_frame("t3_empty", 32'h11223344, 3'd4, 3'd0, 64'hA500000000000000, 2, 8'd4);

    // Input changes and send re-pulse while busy
    cap.delete();
    base = ds_cnt;
    start_frame(32'h11223344, 3'd0, 3'd0);
    repeat (3) @(negedge clock);
    data_in = 32'hDEADBEEF; win_start = 3'd2; win_len = 3'd1; send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    wait_done(base + 1, ok);
    check("t4_done", 32'(ok), 32'd1);
    check_frame("t4", 64'hA511223344440000, 6);
    repeat (60) @(negedge clock);
    check("t4_ds_once", 32'(ds_cnt - base), 32'd1);
    check("t4_fc", 32'(frame_count), 32'd5);
    check("t4_no_extra", 32'(cap.size()), 32'd6);

    // Reset mid-frame after the second byte
    cap.delete();
    base = ds_cnt;
    start_frame(32'h11223344, 3'd0, 3'd0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cap.size() >= 2) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    check("t5_two_bytes", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_wr", 32'(wr_uart), 32'd0);
    check("t5_fc", 32'(frame_count), 32'd0);
    check("t5_no_ds", 32'(ds_cnt - base), 32'd0);
    run_frame("t5_fresh", 32'h11223344, 3'd0, 3'd0, 64'hA511223344440000, 6, 8'd1);

    // 256 back-to-back frames with send held high
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_fc_rst", 32'(frame_count), 32'd0);
    data_in = 32'h11223344; win_start = 3'd3; win_len = 3'd1;
    cap.delete();
    base = ds_cnt;
    bad = 0;
    send = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_done(base + i + 1, ok);
      if (!ok) begin bad++; break; end
      if (!frame_ok(64'hA544440000000000, 3)) bad++;
      cap.delete();
      if (i == 254) send = 1'b0;
    end
    send = 1'b0;
    repeat (40) @(negedge clock);
    check("t6_bad_frames", 32'(bad), 32'd0);
    check("t6_frames", 32'(ds_cnt - base), 32'd256);
    check("t6_fc_wrap", 32'(frame_count), 32'd0);
    check("t6_no_extra", 32'(cap.size()), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("wr_while_busy", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
